// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the EX-stage ALU for ADD/SLL/SRL steps.
// Produces the low XLEN bits of op_a*op_b; the pipeline stalls while busy is high.
module alu_mul_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product,
    output logic [XLEN-1:0] alu_src_a,
    output logic [XLEN-1:0] alu_src_b,
    output logic [2:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
);

    localparam int unsigned CW = $clog2(XLEN + 1);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   iter_cnt;
    logic [CW-1:0]   iter_inc;

    assign iter_inc = iter_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            iter_cnt <= '0;
            product  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        mcand    <= op_a;
                        mplier   <= op_b;
                        iter_cnt <= '0;
                    end
                end
                S_ADD:  acc    <= alu_result;
                S_SHL:  mcand  <= alu_result;
                S_SHR: begin
                    mplier   <= alu_result;
                    iter_cnt <= iter_inc;
                end
                S_DONE: product <= acc;
                default: ;
            endcase
        end
    end

    // ALU operands depend only on state and registers; alu_result/alu_zero steer next state only.
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        alu_src_a = '0;
        alu_src_b = '0;
        alu_ctrl  = ALU_ADD;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (op_b == '0) begin
                        state_nx = S_DONE;
                    end else if (op_b[0]) begin
                        state_nx = S_ADD;
                    end else begin
                        state_nx = S_SHL;
                    end
                end
            end
            S_ADD: begin
                alu_src_a = acc;
                alu_src_b = mcand;
                alu_ctrl  = ALU_ADD;
                state_nx  = S_SHL;
            end
            S_SHL: begin
                alu_src_a = mcand;
                alu_src_b = XLEN'(1);
                alu_ctrl  = ALU_SLL;
                state_nx  = S_SHR;
            end
            S_SHR: begin
                alu_src_a = mplier;
                alu_src_b = XLEN'(1);
                alu_ctrl  = ALU_SRL;
                if (alu_zero || (iter_inc == CW'(XLEN))) begin
                    state_nx = S_DONE;
                end else if (alu_result[0]) begin
                    state_nx = S_ADD;
                end else begin
                    state_nx = S_SHL;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: models the ALU, predicts the per-cycle ALU request trace
// from the shift-add algorithm, and checks every cycle plus directed literal cases.
module tb_alu_mul_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] product;
    logic [XLEN-1:0] alu_src_a;
    logic [XLEN-1:0] alu_src_b;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    alu_mul_sequencer #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execute-stage ALU as seen by the sequencer
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_src_a + alu_src_b;
            3'b110:  alu_result = alu_src_a << alu_src_b[4:0];
            3'b111:  alu_result = alu_src_a >> alu_src_b[4:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of expected per-cycle ALU requests for the running operation
    typedef struct packed {
        logic        is_done;
        logic [31:0] sa;
        logic [31:0] sb;
        logic [2:0]  ctrl;
    } item_t;

    item_t       q[$];
    logic [31:0] model_prod = '0;
    logic [31:0] pend_prod  = '0;

    function automatic item_t mk(input logic d, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] c);
        item_t it;
        it.is_done = d;
        it.sa      = a;
        it.sb      = b;
        it.ctrl    = c;
        return it;
    endfunction

    function automatic void build(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] acc = '0;
        logic [31:0] mc  = a;
        logic [31:0] mp  = b;
        int          n   = 0;
        if (b != 0) begin
            forever begin
                if (mp[0]) begin
                    q.push_back(mk(1'b0, acc, mc, 3'b000));
                    acc = acc + mc;
                end
                q.push_back(mk(1'b0, mc, 32'd1, 3'b110));
                mc = mc << 1;
                q.push_back(mk(1'b0, mp, 32'd1, 3'b111));
                mp = mp >> 1;
                n++;
                if (mp == 0 || n == 32) break;
            end
        end
        q.push_back(mk(1'b1, 32'd0, 32'd0, 3'b000));
        pend_prod = a * b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_prod = '0;
        end else if (q.size() != 0) begin
            item_t it;
            it = q.pop_front();
            if (it.is_done) model_prod = pend_prod;
        end else if (start) begin
            build(op_a, op_b);
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            item_t e;
            logic  eb;
            eb = (q.size() != 0);
            e  = eb ? q[0] : mk(1'b0, 32'd0, 32'd0, 3'b000);
            chk("busy",      {31'd0, busy}, {31'd0, eb});
            chk("done",      {31'd0, done}, {31'd0, e.is_done});
            chk("alu_src_a", alu_src_a, e.sa);
            chk("alu_src_b", alu_src_b, e.sb);
            chk("alu_ctrl",  {29'd0, alu_ctrl}, {29'd0, e.ctrl});
            chk("product",   product, model_prod);
        end
    end

    // Called at a negedge while idle; returns the cycle index in which done was seen
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_prod, input int exp_cyc);
        int cyc;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_done_cycle"}, cyc, exp_cyc);
        @(negedge clk);
        chk({name, "_product"}, product, exp_prod);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_busy",    {31'd0, busy}, 32'd0);
        chk("reset_done",    {31'd0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("t1_3x5",      32'd3,        32'd5,        32'd15,         9);
        run_op("t2_bzero",    32'h1234,     32'd0,        32'd0,          1);
        run_op("t3_7xffff",   32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9,   97);
        run_op("t4_neg1x2",   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   6);

        // Extra start pulses while busy are ignored; start right after DONE is accepted
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd5;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = (c >= 2 && c <= 4);
            op_a  = 32'd9;
            op_b  = 32'd9;
        end
        chk("t5_done_c9", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t5_product", product, 32'd15);
        run_op("t5_2x2", 32'd2, 32'd2, 32'd4, 6);

        // Reset mid-operation aborts without a done pulse
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk("t6_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy",    {31'd0, busy}, 32'd0);
        chk("t6_done",    {31'd0, done}, 32'd0);
        chk("t6_product", product, 32'd0);
        chk("t6_alu",     {alu_src_a[7:0], alu_src_b[7:0], 13'd0, alu_ctrl}, 32'd0);

        // Randomized traffic including start during busy/DONE and occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op_a  = $urandom;
            case ($urandom_range(0, 4))
                0:       op_b = 32'd0;
                1:       op_b = $urandom_range(0, 15);
                2:       op_b = 32'hFFFFFFFF;
                3:       op_b = 32'd1 << $urandom_range(0, 31);
                default: op_b = $urandom;
            endcase
            rst = ($urandom_range(0, 299) == 0);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (120) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
